// File: rtl/fpu_ss_pkg.sv
// rtl/fpu_ss_pkg.sv - shared types and constants for the FPU subsystem memory interface
package fpu_ss_pkg;

  localparam int X_ID_WIDTH  = 4;
  localparam int X_MEM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    ADDR        = 2'd2,
    DATA        = 2'd3
  } xmem_state_e;

  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } mem_size_e;

  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [31:0]            addr;
    logic [1:0]             mode;
    mem_size_e              size;
    logic                   we;
    logic [X_MEM_WIDTH-1:0] wdata;
    logic                   last;
    logic                   spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
    logic                   dbg;
  } x_mem_result_t;

endpackage

// File: rtl/x_mem_lane_align.sv
// rtl/x_mem_lane_align.sv - byte-lane alignment, byte enables and misalignment detection
module x_mem_lane_align
  import fpu_ss_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_shifted;

  assign wdata_o = wdata_i << {offset_i, 3'b000};

  // Size-dependent byte enables, misalignment and zero-filled read extraction
  always_comb begin
    misaligned_o  = 1'b0;
    be_o          = 4'hf;
    rdata_shifted = rdata_i >> {offset_i, 3'b000};
    rdata_o       = rdata_shifted;
    case (size_i)
      BYTE: begin
        be_o    = 4'b0001 << offset_i;
        rdata_o = {24'h0, rdata_shifted[7:0]};
      end
      HALF_WORD: begin
        misaligned_o = offset_i[0];
        be_o         = 4'b0011 << offset_i;
        rdata_o      = {16'h0, rdata_shifted[15:0]};
      end
      WORD: begin
        misaligned_o = |offset_i;
      end
      default: begin
        // 64-bit accesses cannot be served on a 32-bit bus
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/x_mem_responder.sv
// rtl/x_mem_responder.sv - cv-x-if memory responder bridging FPU requests onto an OBI data bus
module x_mem_responder
  import fpu_ss_pkg::*;
#(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_MEM_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          x_mem_valid_i,
  output logic          x_mem_ready_o,
  input  x_mem_req_t    x_mem_req_i,
  output x_mem_resp_t   x_mem_resp_o,
  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,
  output logic          x_mem_result_valid_o,
  output x_mem_result_t x_mem_result_o,
  output logic          data_req_o,
  input  logic          data_gnt_i,
  output logic [31:0]   data_addr_o,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic          data_rvalid_i,
  input  logic [31:0]   data_rdata_i,
  input  logic          data_err_i
);

  xmem_state_e            state_q, state_d;
  logic [X_ID_WIDTH-1:0]  id_q, id_d;
  logic [31:0]            addr_q, addr_d;
  mem_size_e              size_q, size_d;
  logic                   we_q, we_d;
  logic [X_MEM_WIDTH-1:0] wdata_q, wdata_d;
  logic                   res_valid_q, res_valid_d;
  logic [X_ID_WIDTH-1:0]  res_id_q, res_id_d;
  logic [X_MEM_WIDTH-1:0] res_rdata_q, res_rdata_d;
  logic                   res_err_q, res_err_d;

  logic        align_misaligned;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic [1:0]  align_offset;
  mem_size_e   align_size;
  logic        commit_req_hit;
  logic        commit_lat_hit;
  logic        unused_req_fields;

  // mode and last carry no meaning for a single-beat responder
  assign unused_req_fields = ^{x_mem_req_i.mode, x_mem_req_i.last};

  // In IDLE the aligner checks the incoming request; otherwise it serves the latched one
  assign align_offset = (state_q == IDLE) ? x_mem_req_i.addr[1:0] : addr_q[1:0];
  assign align_size   = (state_q == IDLE) ? x_mem_req_i.size : size_q;

  x_mem_lane_align u_lane_align (
    .offset_i     (align_offset),
    .size_i       (align_size),
    .wdata_i      (wdata_q),
    .rdata_i      (data_rdata_i),
    .misaligned_o (align_misaligned),
    .be_o         (align_be),
    .wdata_o      (align_wdata),
    .rdata_o      (align_rdata)
  );

  assign commit_req_hit = x_commit_valid_i && (x_commit_i.id == x_mem_req_i.id);
  assign commit_lat_hit = x_commit_valid_i && (x_commit_i.id == id_q);

  assign x_mem_ready_o = (state_q == IDLE);

  // Bus fields are only driven while a request is presented, so they idle at zero
  assign data_req_o   = (state_q == ADDR);
  assign data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_we_o    = data_req_o & we_q;
  assign data_be_o    = data_req_o ? align_be : 4'h0;
  assign data_wdata_o = data_req_o ? align_wdata : 32'h0;

  assign x_mem_result_valid_o = res_valid_q;
  assign x_mem_result_o       = {res_id_q, res_rdata_q, res_err_q, 1'b0};

  // Next state, request latching, accept-cycle response and result capture
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    res_valid_d  = 1'b0;
    res_id_d     = res_id_q;
    res_rdata_d  = res_rdata_q;
    res_err_d    = res_err_q;
    x_mem_resp_o = '0;
    case (state_q)
      IDLE: begin
        if (x_mem_valid_i) begin
          if (align_misaligned) begin
            x_mem_resp_o.exc     = 1'b1;
            x_mem_resp_o.exccode = x_mem_req_i.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
          end else begin
            id_d    = x_mem_req_i.id;
            addr_d  = x_mem_req_i.addr;
            size_d  = x_mem_req_i.size;
            we_d    = x_mem_req_i.we;
            wdata_d = x_mem_req_i.wdata;
            if (!x_mem_req_i.spec) begin
              state_d = ADDR;
            end else if (commit_req_hit) begin
              state_d = x_commit_i.commit_kill ? IDLE : ADDR;
            end else begin
              state_d = WAIT_COMMIT;
            end
          end
        end
      end
      WAIT_COMMIT: begin
        if (commit_lat_hit) begin
          state_d = x_commit_i.commit_kill ? IDLE : ADDR;
        end
      end
      ADDR: begin
        if (data_gnt_i) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (data_rvalid_i) begin
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_rdata_d = align_rdata;
          res_err_d   = data_err_i;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      size_q      <= BYTE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule
